sdf_stage_ctrl: RTL and testbench
=================================

SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 Parameter DELAY, default 128: depth of the controlled delay line in samples; power of two, at least 2; L = log2(DELAY).
REQ-002 Parameter TW_SHIFT, default 0: left shift applied to the twiddle index so later FFT stages reuse the same ROM.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  upstream sample present.
REQ-006 in_last  in  1  qualifies the final sample of a stream; meaningful only when in_valid=1.
REQ-007 in_ready  out  1  controller can accept a sample this cycle.
REQ-008 sr_shift  out  1  shift-enable to the delay line and butterfly datapath.
REQ-009 bf_sel  out  1  0 = bypass/load (input into delay line), 1 = butterfly (sum out, difference into line).
REQ-010 tw_en  out  1  apply twiddle multiply to the current output sample.
REQ-011 tw_addr  out  9  twiddle ROM index; zero-extended result of {cnt[L-1:0]} << TW_SHIFT.
REQ-012 out_valid  out  1  stage output sample valid this cycle.
REQ-013 out_last  out  1  final output sample of the stream.
REQ-014 err_len  out  1  one-cycle pulse: in_last was accepted when (cnt+1) mod 2*DELAY != 0.

Function
REQ-015 Accept = in_valid & in_ready; sr_shift, bf_sel, tw_en, tw_addr, out_valid and out_last are combinational from state, cnt and accept.
REQ-016 States: IDLE, FILL, RUN, DRAIN; in_ready = 1 in IDLE, FILL and RUN, and 0 in DRAIN.
REQ-017 cnt is an (L+1)-bit sample counter that increments on every accept or DRAIN cycle and wraps from 2*DELAY-1 to 0.
REQ-018 bf_sel = cnt[L] on accept cycles, and 0 in DRAIN.
REQ-019 IDLE: the first accept moves to FILL with cnt=1; outputs stay low while there is no accept.
REQ-020 FILL: the first DELAY accepted samples enter the line with out_valid=0; the accept that makes cnt reach DELAY moves to RUN.
REQ-021 RUN: out_valid = accept; tw_en = out_valid & ~cnt[L] (differences are twiddled, sums are not).
REQ-022 FILL/RUN stall: in_valid=0 forces sr_shift=0 and out_valid=0, and the state and cnt hold, so gaps cost no data.
REQ-023 An accept with in_last=1 moves to DRAIN, and the drain counter is loaded with DELAY.
REQ-024 DRAIN: sr_shift=1, out_valid=1, bf_sel=0 and tw_en=~cnt[L] every cycle while the drain counter decrements.
REQ-025 When the drain counter reaches 1, out_last=1 and the next state is IDLE with cnt=0.
REQ-026 Total out_valid cycles equal total accepted samples, and output latency is DELAY accepted samples.
REQ-027 in_last accepted in FILL: err_len pulses and the drain still runs for exactly DELAY cycles.
REQ-028 in_last accepted at a non-multiple of 2*DELAY: err_len pulses and the drain still runs.
REQ-029 in_valid during DRAIN is ignored (in_ready=0); upstream holds the sample until IDLE.
REQ-030 Single-sample stream: accept with in_last=1 from IDLE goes directly to DRAIN, err_len pulses, then DELAY drain cycles follow.

Reset
REQ-031 rst_n low gives state=IDLE, cnt=0, drain counter=0, and all outputs 0 except in_ready=1.
REQ-032 Reset asserted mid-FILL, mid-RUN or mid-DRAIN aborts immediately, emits no out_last, and requires a fresh stream afterwards.

Structure
REQ-033 The shared FFT package holds the state encoding, DATA_W=24 and the FFT size constant N=512.
REQ-034 The datapath instance sdf_delay_line (DELAY x 24-bit re/im, shift-enabled) is the natural companion sub-module and is not contained in this block.
REQ-035 Counter logic is inline with no further sub-modules, and no storage is wider than L+1 bits.

Verification
REQ-036 512 contiguous samples, in_last on #512 -> out_valid first on accept #129, 512 outputs total, out_last on the 128th DRAIN cycle, err_len=0.
REQ-037 Same stream with in_valid=0 on every third cycle -> sr_shift=0 on every gap, output count 512, bf_sel pattern identical to the contiguous case.
REQ-038 RUN accept at cnt=130 -> bf_sel=1, tw_en=0; DRAIN cycle at cnt=5 -> bf_sel=0, tw_en=1, tw_addr=5; with TW_SHIFT=1 the same cycle gives tw_addr=10.
REQ-039 in_last on sample #300 -> err_len pulses once, DRAIN lasts 128 cycles, in_ready=0 throughout DRAIN.
REQ-040 in_valid held high during DRAIN -> no accept until IDLE, then a new stream starts with cnt=1 and out_valid=0.
REQ-041 rst_n pulsed at RUN sample #200 -> next cycle state IDLE, all outputs 0, in_ready=1, no out_last.

Source files
------------

// File: rtl/sdf_stage_ctrl_pkg.sv
// Shared FFT definitions: stage-controller state encoding and datapath sizing.
package sdf_stage_ctrl_pkg;

  localparam int DATA_W    = 24;
  localparam int N         = 512;
  localparam int TW_ADDR_W = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } sdf_state_e;

endpackage

// File: rtl/sdf_stage_ctrl.sv
// Single-path delay-feedback FFT stage controller: sequences the delay line,
// butterfly select and twiddle index for one radix-2 stage, then drains it.
module sdf_stage_ctrl
  import sdf_stage_ctrl_pkg::*;
#(
  parameter int DELAY    = 128,
  parameter int TW_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 sr_shift,
  output logic                 bf_sel,
  output logic                 tw_en,
  output logic [TW_ADDR_W-1:0] tw_addr,
  output logic                 out_valid,
  output logic                 out_last,
  output logic                 err_len
);

  localparam int L = $clog2(DELAY);

  typedef logic [L:0] cnt_t;

  localparam cnt_t DELAY_C = cnt_t'(DELAY);
  localparam cnt_t ONE_C   = cnt_t'(1);

  sdf_state_e state, state_nxt;
  cnt_t       cnt, cnt_nxt;
  cnt_t       dcnt, dcnt_nxt;
  cnt_t       cnt_inc;
  logic       accept;
  logic [TW_ADDR_W-1:0] tw_idx;

  // cnt is L+1 bits wide, so the increment wraps at 2*DELAY on its own
  assign cnt_inc = cnt + ONE_C;
  assign tw_idx  = TW_ADDR_W'(cnt[L-1:0]) << TW_SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dcnt_nxt  = dcnt;
    accept    = 1'b0;
    in_ready  = 1'b1;
    sr_shift  = 1'b0;
    bf_sel    = 1'b0;
    tw_en     = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    err_len   = 1'b0;

    case (state)
      ST_IDLE, ST_FILL, ST_RUN: begin
        accept = in_valid;
        // No accept means a stall: state and cnt hold, nothing shifts.
        if (accept) begin
          sr_shift  = 1'b1;
          bf_sel    = cnt[L];
          out_valid = (state == ST_RUN);
          tw_en     = out_valid & ~cnt[L];
          cnt_nxt   = cnt_inc;
          if (in_last) begin
            state_nxt = ST_DRAIN;
            dcnt_nxt  = DELAY_C;
            err_len   = (cnt_inc != '0);
          end else if (state == ST_IDLE) begin
            state_nxt = ST_FILL;
          end else if (state == ST_FILL && cnt_inc == DELAY_C) begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        // Flush the DELAY samples still held in the line, butterfly bypassed.
        in_ready  = 1'b0;
        sr_shift  = 1'b1;
        out_valid = 1'b1;
        tw_en     = ~cnt[L];
        cnt_nxt   = cnt_inc;
        dcnt_nxt  = dcnt - ONE_C;
        if (dcnt == ONE_C) begin
          out_last  = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          dcnt_nxt  = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    tw_addr = out_valid ? tw_idx : '0;
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed bench for sdf_stage_ctrl; a second instance with TW_SHIFT=1 shares the inputs.
module tb_sdf_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_last;
  logic       in_ready, sr_shift, bf_sel, tw_en, out_valid, out_last, err_len;
  logic [8:0] tw_addr;
  logic       in_ready_b, sr_shift_b, bf_sel_b, tw_en_b, out_valid_b, out_last_b, err_len_b;
  logic [8:0] tw_addr_b;

  int checks = 0, failures = 0;
  int n_acc, n_ov, n_last, n_err, n_drain, first_ov, last_at, bf_bad, gap_bad, held;

  localparam logic [15:0] IDLE_V = {7'b1000000, 9'd0};

  always #5 clk = ~clk;

  sdf_stage_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .sr_shift(sr_shift), .bf_sel(bf_sel), .tw_en(tw_en),
    .tw_addr(tw_addr), .out_valid(out_valid), .out_last(out_last), .err_len(err_len)
  );

  sdf_stage_ctrl #(.DELAY(128), .TW_SHIFT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_b), .sr_shift(sr_shift_b), .bf_sel(bf_sel_b), .tw_en(tw_en_b),
    .tw_addr(tw_addr_b), .out_valid(out_valid_b), .out_last(out_last_b), .err_len(err_len_b)
  );

  function automatic logic [15:0] ovec();
    return {in_ready, sr_shift, bf_sel, tw_en, out_valid, out_last, err_len, tw_addr};
  endfunction

  function automatic logic [15:0] ovec_b();
    return {in_ready_b, sr_shift_b, bf_sel_b, tw_en_b, out_valid_b, out_last_b, err_len_b, tw_addr_b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_acc = 0; n_ov = 0; n_last = 0; n_err = 0; n_drain = 0;
    first_ov = 0; last_at = 0; bf_bad = 0; gap_bad = 0; held = 0;
  endtask

  // Bookkeeping at the falling edge; bf_sel on accept k is 1 for k mod 256 in [128,255].
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        n_acc++;
        if (bf_sel !== (((n_acc - 1) % 256) >= 128)) bf_bad++;
        if (out_valid && first_ov == 0) first_ov = n_acc;
      end
      if (!in_ready) begin
        n_drain++;
        if (bf_sel !== 1'b0) bf_bad++;
      end
      if (in_valid && !in_ready) held++;
      if (!in_valid && in_ready && (sr_shift || out_valid)) gap_bad++;
      if (out_valid) n_ov++;
      if (out_last) begin n_last++; last_at = n_drain; end
      if (err_len) n_err++;
    end
  end

  initial begin
    int sent;
    clr();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    #12;
    chk("reset_outputs", ovec(), IDLE_V);
    chk("reset_outputs_b", ovec_b(), IDLE_V);
    rst_n = 1'b1;
    step();
    chk("idle_no_accept", ovec(), IDLE_V);

    // Contiguous 512-sample stream
    clr();
    for (int i = 1; i <= 512; i++) begin
      in_valid = 1'b1; in_last = (i == 512);
      #1;
      if (i == 1) chk("first_accept", {sr_shift, out_valid, bf_sel}, 3'b100);
      if (i == 128) chk("fill_last_no_out", out_valid, 1'b0);
      if (i == 131) begin
        chk("run_cnt130_bf_tw", {bf_sel, tw_en, out_valid}, 3'b101);
        chk("run_cnt130_addr", tw_addr, 9'd2);
        chk("run_cnt130_addr_b", tw_addr_b, 9'd4);
      end
      if (i == 512) chk("last_accept", {out_valid, err_len, bf_sel}, 3'b101);
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    for (int d = 1; d <= 128; d++) begin
      #1;
      if (d == 1) chk("drain_ready_low", in_ready, 1'b0);
      if (d == 6) begin
        chk("drain_cnt5_ctl", {bf_sel, tw_en, out_valid, sr_shift}, 4'b0111);
        chk("drain_cnt5_addr", tw_addr, 9'd5);
        chk("drain_cnt5_addr_b", tw_addr_b, 9'd10);
      end
      if (d == 127) chk("drain_127_no_last", out_last, 1'b0);
      if (d == 128) chk("drain_128_last", out_last, 1'b1);
      step();
    end
    chk("a_out_count", n_ov, 512);
    chk("a_first_out_accept", first_ov, 129);
    chk("a_last_count", n_last, 1);
    chk("a_last_drain_cycle", last_at, 128);
    chk("a_err_count", n_err, 0);
    chk("a_drain_cycles", n_drain, 128);
    chk("a_bf_pattern", bf_bad, 0);
    chk("a_back_idle", ovec(), IDLE_V);

    // Same stream with a gap every third cycle
    clr();
    sent = 0;
    for (int c = 0; sent < 512 && c < 2000; c++) begin
      if (c % 3 == 2) begin
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        if (c == 401) chk("gap_stall", {sr_shift, out_valid}, 2'b00);
      end else begin
        sent++;
        in_valid = 1'b1; in_last = (sent == 512);
      end
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    for (int d = 1; d <= 128; d++) step();
    chk("b_sent", sent, 512);
    chk("b_out_count", n_ov, 512);
    chk("b_gap_shift", gap_bad, 0);
    chk("b_bf_pattern", bf_bad, 0);
    chk("b_first_out_accept", first_ov, 129);
    chk("b_last_count", n_last, 1);
    chk("b_err_count", n_err, 0);

    // Short stream ending on sample 300, in_valid held through drain
    clr();
    for (int i = 1; i <= 300; i++) begin
      in_valid = 1'b1; in_last = (i == 300);
      #1;
      if (i == 300) begin
        chk("c_last_ctl", {err_len, out_valid, tw_en, bf_sel}, 4'b1110);
        chk("c_last_addr", tw_addr, 9'd43);
        chk("c_last_addr_b", tw_addr_b, 9'd86);
      end
      step();
    end
    in_last = 1'b0;
    for (int d = 1; d <= 128; d++) begin
      #1;
      if (d == 1) chk("c_drain_ready_low", in_ready, 1'b0);
      step();
    end
    chk("c_err_count", n_err, 1);
    chk("c_drain_cycles", n_drain, 128);
    chk("c_held_in_drain", held, 128);
    chk("c_accepts", n_acc, 300);
    chk("c_out_count", n_ov, 300);
    chk("c_last_count", n_last, 1);
    chk("c_bf_pattern", bf_bad, 0);

    // Held sample starts a new stream, then reset lands at RUN sample 200
    clr();
    for (int i = 1; i <= 200; i++) begin
      in_valid = 1'b1;
      #1;
      if (i == 1) chk("d_restart", {in_ready, sr_shift, out_valid, err_len}, 4'b1100);
      if (i == 200) chk("d_run_200", out_valid, 1'b1);
      if (i < 200) step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("d_reset_async", ovec(), IDLE_V);
    step();
    chk("d_reset_held", ovec(), IDLE_V);
    rst_n = 1'b1;
    step();
    chk("d_after_reset", ovec(), IDLE_V);
    chk("d_first_out_accept", first_ov, 129);
    chk("d_no_last", n_last, 0);

    // in_last accepted during FILL
    clr();
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in_last = (i == 10);
      #1;
      if (i == 10) chk("e_fill_last", {err_len, out_valid, sr_shift}, 3'b101);
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    for (int d = 1; d <= 128; d++) step();
    chk("e_out_count", n_ov, 128);
    chk("e_drain_cycles", n_drain, 128);
    chk("e_last_count", n_last, 1);
    chk("e_err_count", n_err, 1);
    chk("e_back_idle", ovec(), IDLE_V);

    // Single-sample stream
    clr();
    in_valid = 1'b1; in_last = 1'b1;
    #1;
    chk("f_single", {err_len, in_ready, out_valid, sr_shift}, 4'b1101);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    chk("f_drain_ready_low", in_ready, 1'b0);
    for (int d = 1; d <= 128; d++) step();
    chk("f_out_count", n_ov, 128);
    chk("f_drain_cycles", n_drain, 128);
    chk("f_last_count", n_last, 1);
    chk("f_err_count", n_err, 1);
    chk("f_back_idle", ovec(), IDLE_V);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
